// File: rtl/fp_fle.sv
// Registered binary32 comparator producing le/lt/eq and the signaling-compare invalid flag.
// A single 31-bit magnitude compare is shared by all three relations; results appear one cycle after in_valid.
module fp_fle (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] fp_a,
  input  logic [31:0] fp_b,
  output logic        out_valid,
  output logic        le,
  output logic        lt,
  output logic        eq,
  output logic        nv
);

  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic [30:0] mag_a, mag_b;
  logic        nan_a, nan_b, zero_a, zero_b;
  logic        any_nan, both_zero;
  logic        mag_lt, mag_eq;
  logic        lt_raw, eq_raw;

  logic out_valid_d, out_valid_q;
  logic le_d, le_q;
  logic lt_d, lt_q;
  logic eq_d, eq_q;
  logic nv_d, nv_q;

  always_comb begin
    sign_a    = fp_a[31];
    sign_b    = fp_b[31];
    exp_a     = fp_a[30:23];
    exp_b     = fp_b[30:23];
    frac_a    = fp_a[22:0];
    frac_b    = fp_b[22:0];
    mag_a     = fp_a[30:0];
    mag_b     = fp_b[30:0];
    nan_a     = (exp_a == 8'hFF) && (frac_a != 23'd0);
    nan_b     = (exp_b == 8'hFF) && (frac_b != 23'd0);
    zero_a    = (mag_a == 31'd0);
    zero_b    = (mag_b == 31'd0);
    any_nan   = nan_a | nan_b;
    both_zero = zero_a & zero_b;
  end

  // Infinities and subnormals order correctly as plain magnitudes, so no special paths.
  always_comb begin
    mag_lt = (mag_a < mag_b);
    mag_eq = (mag_a == mag_b);
  end

  always_comb begin
    lt_raw = 1'b0;
    if (both_zero)
      lt_raw = 1'b0;
    else if (sign_a != sign_b)
      lt_raw = sign_a;
    else if (!sign_a)
      lt_raw = mag_lt;
    else
      lt_raw = !mag_lt && !mag_eq;
    eq_raw = both_zero | ((sign_a == sign_b) & mag_eq);
  end

  always_comb begin
    out_valid_d = in_valid;
    le_d        = le_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    nv_d        = nv_q;
    if (in_valid) begin
      lt_d = !any_nan & lt_raw;
      eq_d = !any_nan & eq_raw;
      le_d = !any_nan & (lt_raw | eq_raw);
      nv_d = any_nan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      le_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      nv_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      le_q        <= le_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      nv_q        <= nv_d;
    end
  end

  assign out_valid = out_valid_q;
  assign le        = le_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign nv        = nv_q;

endmodule

// File: tb/tb_fp_fle.sv
// Scoreboard bench for fp_fle: directed corner pairs plus random operands checked against an ordering-key model.
module tb_fp_fle;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] fp_a, fp_b;
  logic        out_valid, le, lt, eq, nv;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  logic [3:0] sb[$];
  logic [3:0] last_exp = 4'b0;
  logic       exp_v;

  fp_fle dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .fp_a(fp_a), .fp_b(fp_b),
    .out_valid(out_valid), .le(le), .lt(lt), .eq(eq), .nv(nv)
  );

  always #5 clk = ~clk;

  // Model: map each non-NaN value onto a signed integer that preserves numeric order (+0 and -0 both map to 0).
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic longint order_key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [3:0] model(input logic [31:0] a, input logic [31:0] b);
    longint ka, kb;
    if (is_nan(a) || is_nan(b)) return 4'b0001;
    ka = order_key(a);
    kb = order_key(b);
    return {ka <= kb, ka < kb, ka == kb, 1'b0};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) exp_v <= 1'b0;
    else        exp_v <= in_valid;

  always @(negedge clk) begin
    if (run && rst_n) begin
      logic [3:0] e;
      total++;
      if (out_valid !== exp_v) begin
        bad++;
        $display("FAIL out_valid: got %b want %b", out_valid, exp_v);
      end
      if (out_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got out_valid=1 want no result pending");
        end else begin
          e = sb.pop_front();
          if ({le, lt, eq, nv} !== e) begin
            bad++;
            $display("FAIL result: got le/lt/eq/nv=%b want %b", {le, lt, eq, nv}, e);
          end
          last_exp = e;
        end
      end else begin
        total++;
        if ({le, lt, eq, nv} !== last_exp) begin
          bad++;
          $display("FAIL hold: got le/lt/eq/nv=%b want %b", {le, lt, eq, nv}, last_exp);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic v);
    fp_a = a;
    fp_b = b;
    in_valid = v;
    if (v) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: return {s, 31'd0};
      1: return {s, 8'hFF, 23'd0};
      2: return {s, 8'hFF, 1'b1, 22'($urandom)};
      3: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 22'h3FFFFF))};
      4: return {s, 8'h00, 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  logic [63:0] directed [] = '{
    {32'h3F000000, 32'h3F800000}, {32'h3F800000, 32'h3F000000},
    {32'hC2480000, 32'hC1000000}, {32'hC1000000, 32'hC2480000},
    {32'hBF800000, 32'h00000000}, {32'h00000000, 32'hBF800000},
    {32'h3F800000, 32'h3F800000}, {32'h80000000, 32'h00000000},
    {32'h7F800000, 32'h7F800000}, {32'hFF800000, 32'hFF800000},
    {32'h7FC00000, 32'h3F800000}, {32'h3F800000, 32'h7FC00000},
    {32'h7F800001, 32'h3F800000}, {32'h3F800000, 32'h7F800001},
    {32'h00000001, 32'h00000002}, {32'h00000002, 32'h00000001},
    {32'h00080000, 32'h3F000000}, {32'h00800000, 32'h00000000},
    {32'h7F7FFFFF, 32'h7F800000}, {32'hFF800000, 32'h7F7FFFFF},
    {32'h80000000, 32'h80800000}, {32'h00000000, 32'h80000000}
  };

  initial begin
    logic [31:0] a, b;
    logic [63:0] p;
    rst_n = 1'b0;
    in_valid = 1'b0;
    fp_a = 32'd0;
    fp_b = 32'd0;
    #2;
    total++;
    if ({out_valid, le, lt, eq, nv} !== 5'b0) begin
      bad++;
      $display("FAIL reset_state: got %b want 00000", {out_valid, le, lt, eq, nv});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run = 1'b1;

    foreach (directed[i]) begin
      p = directed[i];
      send(p[63:32], p[31:0], 1'b1);
    end
    send(32'h0, 32'h0, 1'b0);
    send(32'h3F800000, 32'h3F000000, 1'b0);
    send(32'h3F800000, 32'h40000000, 1'b1);
    send(32'hC0000000, 32'h3F800000, 1'b1);
    send(32'h40000000, 32'h40000000, 1'b1);
    send(32'h0, 32'h0, 1'b0);
    send(32'h0, 32'h0, 1'b0);

    // Mid-stream async reset while a result is being presented.
    send(32'h3F800000, 32'h3F800000, 1'b1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    last_exp = 4'b0;
    #1;
    total++;
    if ({out_valid, le, lt, eq, nv} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset: got %b want 00000", {out_valid, le, lt, eq, nv});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      a = rand_op();
      case ($urandom_range(0, 7))
        0, 1: b = a;
        2:    b = a ^ 32'h80000000;
        3:    b = a + 32'($urandom_range(0, 2)) - 32'd1;
        default: b = rand_op();
      endcase
      if ($urandom_range(0, 1)) send(a, b, 1'b1);
      else                      send(b, a, $urandom_range(0, 4) != 0);
    end
    send(32'h0, 32'h0, 1'b0);
    send(32'h0, 32'h0, 1'b0);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
